// File: rtl/alsu_result_buffer.sv
// First-word-fall-through result FIFO behind the ALSU: buffers {err, out} with a sticky overflow flag.
// Optional error counter is built only when ALSU_RB_ERR_CNT_EN is defined; otherwise err_count is 8'h00.
module alsu_result_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [5:0]               alsu_out,
  input  logic [15:0]              alsu_leds,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [6:0]               m_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [7:0]               err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic          err;
  logic          push;
  logic          pop;
  logic          drop;

  assign empty    = (occ == CW'(0));
  assign full     = (occ == CW'(DEPTH));
  assign count    = occ;
  assign m_valid  = !empty;
  assign m_data   = mem[rd_ptr];
  assign err      = (alsu_leds != 16'h0000);
  assign pop      = m_valid && m_ready;
  assign push     = in_valid && (!full || pop);
  assign drop     = in_valid && full && !pop;

  // Storage write; contents are never reset, only the pointers and occupancy are.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {err, alsu_out};
    end
  end

  // Pointers, occupancy and sticky overflow; a new drop wins over clr_ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end
    end
  end

`ifdef ALSU_RB_ERR_CNT_EN
  logic [7:0] err_cnt;

  // Saturating count of accepted error entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'h00;
    end else if (push && err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end else begin
      err_cnt <= err_cnt;
    end
  end

  assign err_count = err_cnt;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_alsu_result_buffer.sv
// Directed self-checking bench for alsu_result_buffer (DEPTH=8).
module tb_alsu_result_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [5:0] alsu_out;
  logic [15:0] alsu_leds;
  logic       m_valid;
  logic       m_ready;
  logic [6:0] m_data;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_ovf;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

`ifdef ALSU_RB_ERR_CNT_EN
  localparam logic [7:0] ERR_ONE = 8'd1;
  localparam logic [7:0] ERR_SAT = 8'd255;
`else
  localparam logic [7:0] ERR_ONE = 8'd0;
  localparam logic [7:0] ERR_SAT = 8'd0;
`endif

  alsu_result_buffer #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alsu_out(alsu_out),
    .alsu_leds(alsu_leds), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .clr_ovf(clr_ovf), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0; alsu_leds = 16'h0000;
  endtask

  task automatic push_val(input logic [5:0] v);
    in_valid = 1'b1; alsu_out = v; m_ready = 1'b0;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alsu_out = 6'h00; idle();
    step(); step();
    rst = 1'b0;
    check("rst_count", count, 4'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_mvalid", m_valid, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_errcnt", err_count, 8'd0);

    // single push, then pop
    push_val(6'h15);
    check("one_mvalid", m_valid, 1'b1);
    check("one_mdata", m_data, 7'h15);
    check("one_count", count, 4'd1);
    m_ready = 1'b1; step(); m_ready = 1'b0;
    check("one_empty", empty, 1'b1);

    // fill to full, drop the 9th
    for (int i = 1; i <= 8; i++) push_val(6'(i));
    check("fill_full", full, 1'b1);
    check("fill_count", count, 4'd8);
    check("fill_ovf", overflow, 1'b0);
    push_val(6'd9);
    check("drop_ovf", overflow, 1'b1);
    check("drop_count", count, 4'd8);
    check("drop_head_stable", m_data, 7'd1);
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", m_data, 32'(i));
      step();
    end
    m_ready = 1'b0;
    check("drain_empty", empty, 1'b1);
    check("ovf_sticky", overflow, 1'b1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("ovf_clr", overflow, 1'b0);

    // full with simultaneous push and pop
    for (int i = 10; i <= 17; i++) push_val(6'(i));
    in_valid = 1'b1; alsu_out = 6'd18; m_ready = 1'b1;
    step();
    in_valid = 1'b0; m_ready = 1'b0;
    check("pp_count", count, 4'd8);
    check("pp_ovf", overflow, 1'b0);
    check("pp_head", m_data, 7'd11);
    m_ready = 1'b1;
    for (int i = 11; i <= 18; i++) begin
      check("pp_order", m_data, 32'(i));
      step();
    end
    m_ready = 1'b0;
    check("pp_empty", empty, 1'b1);

    // drop coinciding with clr_ovf, then reset a half-full FIFO
    for (int i = 20; i <= 27; i++) push_val(6'(i));
    in_valid = 1'b1; alsu_out = 6'd28; clr_ovf = 1'b1;
    step();
    in_valid = 1'b0; clr_ovf = 1'b0;
    check("set_wins", overflow, 1'b1);
    m_ready = 1'b1; step(); step(); step(); step(); m_ready = 1'b0;
    check("half_count", count, 4'd4);
    rst = 1'b1; in_valid = 1'b1; m_ready = 1'b1; clr_ovf = 1'b1;
    step();
    rst = 1'b0; idle();
    check("mid_rst_count", count, 4'd0);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_ovf", overflow, 1'b0);
    check("mid_rst_mvalid", m_valid, 1'b0);

    // error flag and error counter
    alsu_leds = 16'hFFFF; push_val(6'h3F); alsu_leds = 16'h0000;
    check("err_mdata", m_data, 7'h7F);
    check("err_cnt_one", err_count, ERR_ONE);
    m_ready = 1'b1; step(); m_ready = 1'b0;
    alsu_leds = 16'h8000; push_val(6'h02); alsu_leds = 16'h0000;
    check("err_bit_msb", m_data, 7'h42);
    m_ready = 1'b1; step(); m_ready = 1'b0;
    in_valid = 1'b1; m_ready = 1'b1; alsu_leds = 16'h0001; alsu_out = 6'h05;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0; alsu_leds = 16'h0000;
    step(); m_ready = 1'b0;
    check("err_cnt_sat", err_count, ERR_SAT);
    check("err_drain_empty", empty, 1'b1);

    // streaming across pointer wrap
    m_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) check("stream_data", m_data, 32'(k + 31));
      in_valid = 1'b1; alsu_out = 6'(k + 32);
      step();
      check("stream_cnt_le1", 32'(count <= 4'd1), 32'd1);
    end
    in_valid = 1'b0;
    check("stream_last", m_data, 7'd51);
    step();
    m_ready = 1'b0;
    check("stream_empty", empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alsu_result_buffer.md
ALSU_RESULT_BUFFER -- requirements
Module: alsu_result_buffer

Interface
REQ-001 Parameter: DEPTH, 8, FIFO entries; power of 2, range 2..64.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  ALSU result qualifier; the upstream sequencer aligns it with the registered ALSU out/leds.
REQ-005 Port: alsu_out  input  6  ALSU out bus.
REQ-006 Port: alsu_leds  input  16  ALSU leds bus; nonzero means invalid-operation indication.
REQ-007 Port: m_valid  output  1  head entry available.
REQ-008 Port: m_ready  input  1  consumer accepts the head entry.
REQ-009 Port: m_data  output  7  head entry {err, out[5:0]}.
REQ-010 Port: count  output  $clog2(DEPTH)+1  current occupancy.
REQ-011 Port: full  output  1  count == DEPTH.
REQ-012 Port: empty  output  1  count == 0.
REQ-013 Port: overflow  output  1  sticky; a result was dropped.
REQ-014 Port: clr_ovf  input  1  clears overflow.
REQ-015 Port: err_count  output  8  accepted error entries (see Configuration).

Function
REQ-016 pop SHALL equal m_valid && m_ready; push SHALL equal in_valid && (!full || pop).
REQ-017 On push, entry {err, alsu_out} SHALL be written at wr_ptr, with err = (alsu_leds != 0) sampled in the same cycle.
REQ-018 The FIFO SHALL be first-word-fall-through: m_valid = !empty, and m_data = mem[rd_ptr] combinationally from registered storage.
REQ-019 Latency: a result pushed at edge N SHALL appear on m_valid/m_data after edge N, so it is poppable in cycle N+1.
REQ-020 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; count SHALL be a separate register: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-021 Full with simultaneous in_valid and pop: both SHALL occur; count stays DEPTH; no overflow.
REQ-022 Full with in_valid and no pop: the sample SHALL be dropped; overflow SHALL set at the next edge; storage, pointers and count unchanged.
REQ-023 Empty with in_valid: push only; m_ready is ignored while m_valid=0.
REQ-024 overflow SHALL hold until rst or clr_ovf; if clr_ovf and a new drop coincide, overflow SHALL be 1 (set wins).
REQ-025 m_data SHALL remain stable while m_valid=1 and m_ready=0.

Reset
REQ-026 While rst=1 at an edge: wr_ptr, rd_ptr, count, overflow, err_count SHALL be 0; m_valid=0, empty=1, full=0 after that edge.
REQ-027 Reset mid-operation SHALL discard all stored entries and override any same-cycle push, pop or clr_ovf; memory contents need no reset.
REQ-028 m_data value while empty is don't-care.

Configuration
REQ-029 Macro ALSU_RB_ERR_CNT_EN defined: err_count SHALL increment by 1 on each push with err=1, saturating at 255; cleared only by rst.
REQ-030 Macro ALSU_RB_ERR_CNT_EN undefined: err_count SHALL be tied to 8'h00 and no counter logic SHALL be synthesized; all other behaviour identical.

Verification
REQ-031 Reset, then in_valid=1 for 1 cycle with alsu_out=6'h15, leds=0 -> next cycle m_valid=1, m_data=7'h15, count=1; m_ready=1 one cycle -> empty=1.
REQ-032 DEPTH=8, push 8 values 1..8 with m_ready=0 -> full=1, count=8; 9th push (value 9) -> overflow=1, pop order 1..8, value 9 never appears.
REQ-033 Full, in_valid=1 with m_ready=1 same cycle -> count stays 8, overflow stays 0, head advances, new value emerges last.
REQ-034 Push out=6'h3F with leds=16'hFFFF -> m_data=7'h7F; with ALSU_RB_ERR_CNT_EN, err_count=1; 300 error pushes/pops -> err_count=255.
REQ-035 Push 20 values with continuous m_ready=1 across pointer wrap -> output sequence equals input sequence, count never exceeds 1.
REQ-036 Half-full FIFO with overflow=1, assert rst for 1 cycle -> count=0, empty=1, overflow=0, m_valid=0; clr_ovf with simultaneous drop -> overflow stays 1.
